sha256_msg_padder: RTL and testbench
====================================

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 55, meaning the maximum message length in bytes that fits one padded 512-bit block.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port s_data, input, 8 bits: message byte, first byte is the most significant in the block.
REQ-005 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-006 The block SHALL have port s_last, input, 1 bit: the current byte is the final message byte.
REQ-007 The block SHALL have port s_ready, output, 1 bit: the padder accepts a byte this cycle.
REQ-008 The block SHALL have port block_o, output, 512 bits: padded block sent to the compression core.
REQ-009 The block SHALL have port go_o, output, 1 bit: one-cycle start pulse to the core.
REQ-010 The block SHALL have port core_done_i, input, 1 bit: core completion pulse; the digest is valid in the same cycle.
REQ-011 The block SHALL have port core_digest_i, input, 256 bits: core digest.
REQ-012 The block SHALL have port digest_o, output, 256 bits: captured hash result.
REQ-013 The block SHALL have port digest_valid_o, output, 1 bit: one-cycle pulse, digest_o is new.
REQ-014 The block SHALL have port err_o, output, 1 bit: one-cycle pulse, message is overlength and was discarded.

Function
REQ-015 The FSM SHALL have the states COLLECT, PAD, START, WAIT, DONE and DROP.
REQ-016 A byte SHALL be accepted only on s_valid & s_ready; s_ready SHALL be 1 only in COLLECT and DROP.
REQ-017 In COLLECT, a byte accepted with byte count n < MAX_BYTES SHALL be written to block_o[511-8n -: 8], and n SHALL increment (6-bit counter).
REQ-018 In COLLECT, an accepted byte with s_last=1 and n < MAX_BYTES SHALL cause a transition to PAD on the next cycle.
REQ-019 In PAD, the block SHALL write 0x80 to byte position n (count after the last byte) and length n*8 (64-bit big-endian) to block_o[63:0], leave all other bits 0, then go to START.
REQ-020 In START, go_o SHALL be 1 for exactly one cycle, followed by a transition to WAIT.
REQ-021 In WAIT, core_done_i=1 SHALL capture core_digest_i into digest_o and cause a transition to DONE.
REQ-022 core_done_i in any other state SHALL be ignored.
REQ-023 In DONE, digest_valid_o SHALL be 1 for one cycle; the block SHALL then clear block_o and the counter to 0 and return to COLLECT.
REQ-024 block_o SHALL remain stable from entry to START until exit from WAIT.
REQ-025 Latency: with s_last accepted at edge T, go_o SHALL be high during cycle T+2, and digest_valid_o SHALL be high in the cycle after the one where core_done_i is sampled.
REQ-026 Overlength: a byte accepted in COLLECT with n == MAX_BYTES SHALL pulse err_o the next cycle.
REQ-027 On overlength, the FSM SHALL enter DROP, or enter COLLECT with cleared state if that byte has s_last=1.
REQ-028 In DROP, the block SHALL accept and discard bytes until a byte with s_last=1 is accepted, then clear block_o and the counter and return to COLLECT; go_o SHALL NOT assert.
REQ-029 Minimum message length SHALL be 1 byte; zero-length messages are unsupported.
REQ-030 digest_o SHALL hold its value until the next capture.

Reset
REQ-031 On rst=1, the state SHALL be COLLECT, the counter 0, and block_o, digest_o, go_o, digest_valid_o and err_o all 0.
REQ-032 s_ready SHALL be 1 immediately after reset release.
REQ-033 rst asserted in any state, including mid-WAIT, SHALL abort the operation.
REQ-034 A core_done_i arriving after a reset-aborted operation SHALL be ignored.

Verification
REQ-035 The bench SHALL cover: bytes 61,62,63 ("abc") with s_last on 63 -> block_o = 61626380 followed by zeros, with low word 00000018; go_o one cycle at T+2.
REQ-036 The bench SHALL cover: the "abc" block through a real core -> digest_o = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with one digest_valid_o pulse.
REQ-037 The bench SHALL cover: 55 bytes of 0x61 -> byte 55 = 0x80, block_o[63:0] = 0x1B8, no err_o.
REQ-038 The bench SHALL cover: 56 bytes with s_last on the 56th -> err_o one pulse, no go_o, s_ready=1 afterwards, next "abc" message is correct.
REQ-039 The bench SHALL cover: s_valid toggled randomly during "abc" -> block_o identical to the non-stalled case; s_ready=0 from PAD until DONE completes.
REQ-040 The bench SHALL cover: rst pulsed in WAIT, with core_done_i arriving later -> no digest_valid_o, digest_o = 0, COLLECT with count 0.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// Collects a short message byte stream into one padded SHA-256 block, starts the
// compression core, and captures the resulting digest. Overlength messages are dropped.
module sha256_msg_padder #(
  parameter int unsigned MAX_BYTES = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [511:0] block_o,
  output logic         go_o,
  input  logic         core_done_i,
  input  logic [255:0] core_digest_i,
  output logic [255:0] digest_o,
  output logic         digest_valid_o,
  output logic         err_o
);

  localparam logic [5:0] MaxCnt = 6'(MAX_BYTES);

  typedef enum logic [2:0] {
    StCollect,
    StPad,
    StStart,
    StWait,
    StDone,
    StDrop
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [511:0]   block_q, block_d;
  logic [255:0]   digest_q, digest_d;
  logic           err_q, err_d;
  logic           accept;
  logic [8:0]     byte_msb;

  assign s_ready  = (state_q == StCollect) || (state_q == StDrop);
  assign accept   = s_valid & s_ready;
  // MSB bit index of byte slot n; byte 0 sits at the top of the block.
  assign byte_msb = 9'd511 - {cnt_q, 3'b000};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    block_d        = block_q;
    digest_d       = digest_q;
    err_d          = 1'b0;
    go_o           = 1'b0;
    digest_valid_o = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (cnt_q < MaxCnt) begin
            block_d[byte_msb -: 8] = s_data;
            cnt_d                  = cnt_q + 6'd1;
            if (s_last) begin
              state_d = StPad;
            end
          end else begin
            err_d = 1'b1;
            if (s_last) begin
              block_d = '0;
              cnt_d   = '0;
              state_d = StCollect;
            end else begin
              state_d = StDrop;
            end
          end
        end
      end
      StPad: begin
        block_d[byte_msb -: 8] = 8'h80;
        block_d[63:0]          = {55'd0, cnt_q, 3'b000};
        state_d                = StStart;
      end
      StStart: begin
        go_o    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (core_done_i) begin
          digest_d = core_digest_i;
          state_d  = StDone;
        end
      end
      StDone: begin
        digest_valid_o = 1'b1;
        block_d        = '0;
        cnt_d          = '0;
        state_d        = StCollect;
      end
      StDrop: begin
        if (accept && s_last) begin
          block_d = '0;
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StCollect;
      cnt_q    <= '0;
      block_q  <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      digest_q <= digest_d;
      err_q    <= err_d;
    end
  end

  assign block_o  = block_q;
  assign digest_o = digest_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized self-checking bench for sha256_msg_padder; a behavioural SHA-256 compression
// function stands in for the core and padded blocks are predicted by plain arithmetic.
module tb_sha256_msg_padder;

  localparam int unsigned MaxBytes = 55;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] block_o;
  logic         go_o;
  logic         core_done_i;
  logic [255:0] core_digest_i;
  logic [255:0] digest_o;
  logic         digest_valid_o;
  logic         err_o;

  int n_checks = 0;
  int n_errors = 0;
  int go_cnt   = 0;
  int err_cnt  = 0;
  int dv_cnt   = 0;

  logic [7:0]   msg_q [$];
  logic [511:0] exp_block;
  logic [255:0] exp_digest;

  sha256_msg_padder #(.MAX_BYTES(MaxBytes)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .block_o       (block_o),
    .go_o          (go_o),
    .core_done_i   (core_done_i),
    .core_digest_i (core_digest_i),
    .digest_o      (digest_o),
    .digest_valid_o(digest_valid_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (go_o) go_cnt <= go_cnt + 1;
    if (err_o) err_cnt <= err_cnt + 1;
    if (digest_valid_o) dv_cnt <= dv_cnt + 1;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single-block SHA-256 compression from the standard initial hash value.
  function automatic logic [255:0] sha256_block(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1, ch, maj;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      ch  = (e & f) ^ (~e & g);
      t1  = h + s1 + ch + K[i] + w[i];
      s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      maj = (a & b) ^ (a & c) ^ (b & c);
      t2  = s0 + maj;
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  // Message bytes, then 0x80, shifted to the top; bit length in the low 64 bits.
  function automatic logic [511:0] pad_model();
    logic [511:0] v;
    int           len;
    len = msg_q.size();
    v   = '0;
    foreach (msg_q[i]) v = (v << 8) | 512'(msg_q[i]);
    v       = (v << 8) | 512'h80;
    v       = v << (8 * (63 - len));
    v[63:0] = 64'(len * 8);
    return v;
  endfunction

  task automatic set_msg_random(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom()));
  endtask

  task automatic set_msg_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // Returns #1 after the edge that accepted the final byte.
  task automatic send_msg(input bit stall);
    int i;
    int guard;
    bit acc;
    i     = 0;
    guard = 0;
    while (i < msg_q.size()) begin
      if (guard > 2000) begin
        check("send_timeout", 512'(guard), 512'(0));
        break;
      end
      guard++;
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = msg_q[i];
      s_last  = (i == msg_q.size() - 1);
      acc     = s_valid & s_ready;
      @(posedge clk); #1;
      if (acc) i++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  // Sends a legal message and follows it to WAIT, checking latency and the block.
  task automatic send_and_pad(input bit stall);
    int g0, e0;
    exp_block  = pad_model();
    exp_digest = sha256_block(exp_block);
    g0 = go_cnt;
    e0 = err_cnt;
    send_msg(stall);
    check("pad_ready", 512'(s_ready), 512'(1'b0));
    check("pad_go", 512'(go_o), 512'(1'b0));
    @(posedge clk); #1;
    check("start_go", 512'(go_o), 512'(1'b1));
    check("start_block", block_o, exp_block);
    check("start_ready", 512'(s_ready), 512'(1'b0));
    @(posedge clk); #1;
    check("wait_go", 512'(go_o), 512'(1'b0));
    check("wait_block", block_o, exp_block);
    check("go_count", 512'(go_cnt - g0), 512'(1));
    check("no_err", 512'(err_cnt - e0), 512'(0));
  endtask

  task automatic finish_core(input int delay);
    int d0;
    d0 = dv_cnt;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("wait_hold_block", block_o, exp_block);
      check("wait_ready", 512'(s_ready), 512'(1'b0));
    end
    core_done_i   = 1'b1;
    core_digest_i = exp_digest;
    @(posedge clk); #1;
    core_done_i = 1'b0;
    for (int k = 0; k < 8; k++) core_digest_i[32 * k +: 32] = $urandom();
    check("done_dv", 512'(digest_valid_o), 512'(1'b1));
    check("done_digest", 512'(digest_o), 512'(exp_digest));
    check("done_ready", 512'(s_ready), 512'(1'b0));
    @(posedge clk); #1;
    check("post_dv", 512'(digest_valid_o), 512'(1'b0));
    check("post_ready", 512'(s_ready), 512'(1'b1));
    check("post_block_clear", block_o, 512'(0));
    check("post_digest_hold", 512'(digest_o), 512'(exp_digest));
    check("dv_count", 512'(dv_cnt - d0), 512'(1));
  endtask

  task automatic send_overlength(input bit stall);
    int g0, e0;
    g0 = go_cnt;
    e0 = err_cnt;
    send_msg(stall);
    if (msg_q.size() == MaxBytes + 1) begin
      check("ovl_err_pulse", 512'(err_o), 512'(1'b1));
    end
    check("ovl_ready", 512'(s_ready), 512'(1'b1));
    check("ovl_block_clear", block_o, 512'(0));
    @(posedge clk); #1;
    check("ovl_err_low", 512'(err_o), 512'(1'b0));
    check("ovl_err_count", 512'(err_cnt - e0), 512'(1));
    check("ovl_no_go", 512'(go_cnt - g0), 512'(0));
    check("ovl_ready_after", 512'(s_ready), 512'(1'b1));
  endtask

  initial begin
    logic [255:0] held;
    int           d0;
    rst           = 1'b1;
    s_data        = '0;
    s_valid       = 1'b0;
    s_last        = 1'b0;
    core_done_i   = 1'b0;
    core_digest_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_block", block_o, 512'(0));
    check("rst_digest", 512'(digest_o), 512'(0));
    check("rst_go", 512'(go_o), 512'(1'b0));
    check("rst_dv", 512'(digest_valid_o), 512'(1'b0));
    check("rst_err", 512'(err_o), 512'(1'b0));
    rst = 1'b0;
    #1;
    check("rst_ready", 512'(s_ready), 512'(1'b1));

    // "abc" through the behavioural core
    set_msg_abc();
    send_and_pad(1'b0);
    check("abc_top_word", 512'(block_o[511:480]), 512'(32'h61626380));
    check("abc_mid_zero", 512'(block_o[479:64]), 512'(0));
    check("abc_len", 512'(block_o[63:0]), 512'(64'h18));
    finish_core(3);
    check("abc_digest", 512'(digest_o),
          512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

    // Longest legal message
    msg_q.delete();
    for (int i = 0; i < MaxBytes; i++) msg_q.push_back(8'h61);
    send_and_pad(1'b0);
    check("max_pad_byte", 512'(block_o[71:64]), 512'(8'h80));
    check("max_len", 512'(block_o[63:0]), 512'(64'h1B8));
    finish_core(1);

    // One byte too long, s_last on the overflowing byte
    set_msg_random(MaxBytes + 1);
    send_overlength(1'b0);
    set_msg_abc();
    send_and_pad(1'b0);
    finish_core(0);

    // "abc" with random valid gaps
    set_msg_abc();
    send_and_pad(1'b1);
    check("stall_top_word", 512'(block_o[511:480]), 512'(32'h61626380));
    finish_core(2);

    // Reset while waiting for the core; late done must be ignored
    set_msg_abc();
    send_and_pad(1'b0);
    d0 = dv_cnt;
    @(posedge clk);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    check("abort_block", block_o, 512'(0));
    check("abort_digest", 512'(digest_o), 512'(0));
    check("abort_ready", 512'(s_ready), 512'(1'b1));
    @(posedge clk); #1;
    core_done_i   = 1'b1;
    core_digest_i = exp_digest;
    @(posedge clk); #1;
    core_done_i = 1'b0;
    @(posedge clk); #1;
    check("abort_no_dv", 512'(dv_cnt - d0), 512'(0));
    check("abort_digest_zero", 512'(digest_o), 512'(0));
    check("abort_collect", 512'(s_ready), 512'(1'b1));
    set_msg_abc();
    send_and_pad(1'b0);
    finish_core(1);

    // Random legal and overlength messages, with stray core_done pulses while idle
    for (int n = 0; n < 12; n++) begin
      held = digest_o;
      d0   = dv_cnt;
      core_done_i = 1'b1;
      for (int k = 0; k < 8; k++) core_digest_i[32 * k +: 32] = $urandom();
      @(posedge clk); #1;
      core_done_i = 1'b0;
      @(posedge clk); #1;
      check("idle_done_ignored", 512'(digest_o), 512'(held));
      check("idle_no_dv", 512'(dv_cnt - d0), 512'(0));
      if (n % 4 == 3) begin
        set_msg_random(int'($urandom_range(MaxBytes + 1, MaxBytes + 15)));
        send_overlength(1'($urandom_range(0, 1)));
      end else begin
        set_msg_random(int'($urandom_range(1, MaxBytes)));
        send_and_pad(1'($urandom_range(0, 1)));
        finish_core(int'($urandom_range(0, 5)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
